// File: rtl/regfile_mp.sv
// regfile_mp: multi-port integer register file with issue scoreboard and power-up clear sweep.
// Latency: reads are combinational (zero cycles); writes and scoreboard updates land on the next clk_i edge.
// Backpressure: none; every enabled write is absorbed each cycle once RUN is reached, and inputs are ignored during INIT.
// Optional feature: define REGFILE_MP_BYPASS_EN to forward same-cycle write data to the read ports.
module regfile_mp #(
  parameter int XLEN = 64,
  parameter int NREG = 32,   // must be a power of two
  parameter int NRD  = 2,
  parameter int NWR  = 2,
  localparam int AW  = $clog2(NREG)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,        // asynchronous, active low
  input  logic [NWR-1:0]        wen_i,
  input  logic [NWR*AW-1:0]     rd_i,
  input  logic [NWR*XLEN-1:0]   e_wdata_i,
  input  logic [NWR-1:0]        is_load_i,
  input  logic [NWR*XLEN-1:0]   m_wdata_i,
  input  logic                  iss_valid_i,
  input  logic [AW-1:0]         iss_rd_i,
  input  logic [NRD*AW-1:0]     rs_i,
  output logic [NRD*XLEN-1:0]   src_o,
  output logic [NRD-1:0]        busy_o,
  output logic                  init_done_o
);

  typedef enum logic {
    ST_INIT = 1'b0,
    ST_RUN  = 1'b1
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(NREG - 1);
  localparam logic [AW-1:0] ONE_IDX  = AW'(1);

  state_e              state_q, state_d;
  logic [AW-1:0]       cnt_q, cnt_d;
  logic [NREG-1:0]     busy_q, busy_d;
  logic [XLEN-1:0]     regs_q [NREG];

  // Per-port decoded write requests; a port only counts as a write in RUN and never to index 0.
  logic [AW-1:0]       wrd   [NWR];
  logic [XLEN-1:0]     wdata [NWR];
  logic [NWR-1:0]      wvld;

  // Decode each write port: destination slice, load/execute data select, qualified enable.
  always_comb begin
    for (int k = 0; k < NWR; k++) begin
      wrd[k]   = rd_i[k*AW +: AW];
      wdata[k] = is_load_i[k] ? m_wdata_i[k*XLEN +: XLEN] : e_wdata_i[k*XLEN +: XLEN];
      wvld[k]  = (state_q == ST_RUN) && wen_i[k] && (wrd[k] != '0);
    end
  end

  // Next-state logic: sweep counter in INIT, scoreboard clear-then-set in RUN so issue wins.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    busy_d  = busy_q;
    case (state_q)
      ST_INIT: begin
        // Counter wraps back to 0 after the last index and then rests there in RUN.
        cnt_d = cnt_q + ONE_IDX;
        if (cnt_q == LAST_IDX) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        for (int k = 0; k < NWR; k++) begin
          if (wvld[k]) begin
            busy_d[wrd[k]] = 1'b0;
          end
        end
        if (iss_valid_i && (iss_rd_i != '0)) begin
          busy_d[iss_rd_i] = 1'b1;
        end
      end
      default: begin
        state_d = ST_INIT;
      end
    endcase
  end

  // Control state register; reset aborts anything in flight and restarts the sweep at index 0.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q <= ST_INIT;
      cnt_q   <= '0;
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
    end
  end

  // Storage array has no reset; INIT zeroes one entry per cycle, RUN applies writes with the
  // highest-indexed port winning because its non-blocking assignment is issued last.
  always_ff @(posedge clk_i) begin
    if (state_q == ST_INIT) begin
      regs_q[cnt_q] <= '0;
    end else begin
      for (int k = 0; k < NWR; k++) begin
        if (wvld[k]) begin
          regs_q[wrd[k]] <= wdata[k];
        end
      end
    end
  end

  // Combinational read ports; outputs are held at zero until the sweep completes.
  always_comb begin
    logic [AW-1:0]   ridx;
    logic [XLEN-1:0] rdat;
    logic            rbusy;
    ridx   = '0;
    rdat   = '0;
    rbusy  = 1'b0;
    src_o  = '0;
    busy_o = '0;
    for (int j = 0; j < NRD; j++) begin
      ridx  = rs_i[j*AW +: AW];
      rdat  = '0;
      rbusy = 1'b0;
      if (state_q == ST_RUN) begin
        rdat  = (ridx == '0) ? '0 : regs_q[ridx];
        rbusy = busy_q[ridx];
`ifdef REGFILE_MP_BYPASS_EN
        // Forward the winning same-cycle write; a producer landing now cannot still be pending.
        for (int k = 0; k < NWR; k++) begin
          if (wvld[k] && (wrd[k] == ridx)) begin
            rdat  = wdata[k];
            rbusy = 1'b0;
          end
        end
`endif
      end
      src_o[j*XLEN +: XLEN] = rdat;
      busy_o[j]             = rbusy;
    end
  end

  assign init_done_o = (state_q == ST_RUN);

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table-driven bench for regfile_mp at default parameters.
// Inputs change 1ns after the rising edge; outputs are compared 1ns later, before the next edge.
// Expected values for forwarding cases depend on whether REGFILE_MP_BYPASS_EN is defined.
module tb_regfile_mp;

`ifdef REGFILE_MP_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_i;
  logic [1:0]    wen_i;
  logic [9:0]    rd_i;
  logic [127:0]  e_wdata_i;
  logic [1:0]    is_load_i;
  logic [127:0]  m_wdata_i;
  logic          iss_valid_i;
  logic [4:0]    iss_rd_i;
  logic [9:0]    rs_i;
  logic [127:0]  src_o;
  logic [1:0]    busy_o;
  logic          init_done_o;

  int checks   = 0;
  int failures = 0;

  regfile_mp dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .wen_i       (wen_i),
    .rd_i        (rd_i),
    .e_wdata_i   (e_wdata_i),
    .is_load_i   (is_load_i),
    .m_wdata_i   (m_wdata_i),
    .iss_valid_i (iss_valid_i),
    .iss_rd_i    (iss_rd_i),
    .rs_i        (rs_i),
    .src_o       (src_o),
    .busy_o      (busy_o),
    .init_done_o (init_done_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [1:0]  wen;
    logic [4:0]  rd0, rd1;
    logic [63:0] e0, e1, m0, m1;
    logic [1:0]  isl;
    logic        iv;
    logic [4:0]  ird;
    logic [4:0]  rs0, rs1;
    logic [63:0] x0, x1;
    logic [1:0]  xb;
  } vec_t;

  vec_t tbl [16];

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive_idle();
    wen_i       = '0;
    rd_i        = '0;
    e_wdata_i   = '0;
    is_load_i   = '0;
    m_wdata_i   = '0;
    iss_valid_i = 1'b0;
    iss_rd_i    = '0;
  endtask

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  // Counts edges after reset release until init_done_o rises, bounded at 100.
  // Also drives junk writes/issues and reports whether any read was nonzero during the sweep.
  task automatic wait_init(output int n, output bit src_bad);
    n       = 0;
    src_bad = 1'b0;
    while (!init_done_o && n < 100) begin
      wen_i       = 2'b11;
      rd_i        = {5'd4, 5'd4};
      e_wdata_i   = {64'h5, 64'h5};
      iss_valid_i = 1'b1;
      iss_rd_i    = 5'd6;
      rs_i        = {5'd4, 5'd31};
      #1;
      if (src_o != '0 || busy_o != '0) src_bad = 1'b1;
      @(posedge clk_i);
      #1;
      n++;
    end
    drive_idle();
  endtask

  initial begin
    int  ncyc;
    bit  sbad;

    // {wen, rd0, rd1, e0, e1, m0, m1, isl, iv, ird, rs0, rs1, exp src0, exp src1, exp busy}
    tbl[0]  = '{2'b11, 5'd5, 5'd5, 64'h11, 64'h0, 64'h0, 64'h22, 2'b10, 1'b0, 5'd0, 5'd1, 5'd2, 64'h0, 64'h0, 2'b00};
    tbl[1]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b0, 5'd0, 5'd5, 5'd0, 64'h22, 64'h0, 2'b00};
    tbl[2]  = '{2'b01, 5'd0, 5'd0, 64'hFFFF, 64'h0, 64'h0, 64'h0, 2'b00, 1'b1, 5'd0, 5'd5, 5'd6, 64'h22, 64'h0, 2'b00};
    tbl[3]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b0, 5'd0, 5'd0, 5'd0, 64'h0, 64'h0, 2'b00};
    tbl[4]  = '{2'b11, 5'd10, 5'd11, 64'hA5A5, 64'h9999, 64'h0, 64'hDEADBEEF00000001, 2'b10, 1'b0, 5'd0, 5'd5, 5'd0, 64'h22, 64'h0, 2'b00};
    tbl[5]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b0, 5'd0, 5'd10, 5'd11, 64'hA5A5, 64'hDEADBEEF00000001, 2'b00};
    tbl[6]  = '{2'b01, 5'd12, 5'd12, 64'h66, 64'h55, 64'h77, 64'h0, 2'b01, 1'b0, 5'd0, 5'd10, 5'd11, 64'hA5A5, 64'hDEADBEEF00000001, 2'b00};
    tbl[7]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b0, 5'd0, 5'd12, 5'd5, 64'h77, 64'h22, 2'b00};
    tbl[8]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b1, 5'd7, 5'd7, 5'd8, 64'h0, 64'h0, 2'b00};
    tbl[9]  = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b1, 5'd8, 5'd7, 5'd8, 64'h0, 64'h0, 2'b01};
    tbl[10] = '{2'b01, 5'd7, 5'd0, 64'h70, 64'h0, 64'h0, 64'h0, 2'b00, 1'b1, 5'd7, 5'd8, 5'd9, 64'h0, 64'h0, 2'b01};
    tbl[11] = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b0, 5'd0, 5'd7, 5'd8, 64'h70, 64'h0, 2'b11};
    tbl[12] = '{2'b11, 5'd7, 5'd8, 64'h71, 64'h80, 64'h0, 64'h0, 2'b00, 1'b0, 5'd0, 5'd9, 5'd10, 64'h0, 64'hA5A5, 2'b00};
    tbl[13] = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b0, 5'd0, 5'd7, 5'd8, 64'h71, 64'h80, 2'b00};
    tbl[14] = '{2'b01, 5'd9, 5'd0, 64'h99, 64'h0, 64'h0, 64'h0, 2'b00, 1'b1, 5'd9, 5'd12, 5'd0, 64'h77, 64'h0, 2'b00};
    tbl[15] = '{2'b00, 5'd0, 5'd0, 64'h0, 64'h0, 64'h0, 64'h0, 2'b00, 1'b0, 5'd0, 5'd9, 5'd9, 64'h99, 64'h99, 2'b11};

    // Reset state
    rst_i = 1'b0;
    drive_idle();
    rs_i = {5'd3, 5'd17};
    repeat (3) @(posedge clk_i);
    #1;
    chk("rst_init_done", {63'd0, init_done_o}, 64'd0);
    chk("rst_busy", {62'd0, busy_o}, 64'd0);
    chk("rst_src", src_o[63:0] | src_o[127:64], 64'd0);

    // Sweep length and input blocking during INIT
    rst_i = 1'b1;
    wait_init(ncyc, sbad);
    chk("init_cycles", 64'(ncyc), 64'd32);
    chk("init_src_zero", {63'd0, sbad}, 64'd0);
    rs_i = {5'd6, 5'd4};
    #1;
    chk("init_ignored_wr", src_o[63:0], 64'd0);
    chk("init_ignored_iss", {62'd0, busy_o}, 64'd0);

    // Table vectors
    for (int i = 0; i < 16; i++) begin
      wen_i       = tbl[i].wen;
      rd_i        = {tbl[i].rd1, tbl[i].rd0};
      e_wdata_i   = {tbl[i].e1, tbl[i].e0};
      m_wdata_i   = {tbl[i].m1, tbl[i].m0};
      is_load_i   = tbl[i].isl;
      iss_valid_i = tbl[i].iv;
      iss_rd_i    = tbl[i].ird;
      rs_i        = {tbl[i].rs1, tbl[i].rs0};
      #1;
      chk($sformatf("vec%0d_src0", i), src_o[63:0], tbl[i].x0);
      chk($sformatf("vec%0d_src1", i), src_o[127:64], tbl[i].x1);
      chk($sformatf("vec%0d_busy", i), {62'd0, busy_o}, {62'd0, tbl[i].xb});
      step();
    end

    // Same-cycle write to a read index: forwarded only with bypass
    drive_idle();
    wen_i     = 2'b01;
    rd_i      = {5'd0, 5'd3};
    e_wdata_i = {64'h0, 64'hAB};
    rs_i      = {5'd9, 5'd3};
    #1;
    chk("byp_src_same", src_o[63:0], BYP ? 64'hAB : 64'h0);
    chk("byp_busy9", {62'd0, busy_o}, 64'd2);
    step();
    drive_idle();
    #1;
    chk("byp_src_next", src_o[63:0], 64'hAB);

    // Same-cycle write clear is not visible on busy_o until the next cycle
    iss_valid_i = 1'b1;
    iss_rd_i    = 5'd20;
    rs_i        = {5'd3, 5'd20};
    step();
    drive_idle();
    wen_i     = 2'b01;
    rd_i      = {5'd0, 5'd20};
    e_wdata_i = {64'h0, 64'h20};
    #1;
    chk("clr_busy_same", {63'd0, busy_o[0]}, BYP ? 64'd0 : 64'd1);
    chk("clr_src_same", src_o[63:0], BYP ? 64'h20 : 64'h0);
    step();
    drive_idle();
    #1;
    chk("clr_busy_next", {63'd0, busy_o[0]}, 64'd0);
    chk("clr_src_next", src_o[63:0], 64'h20);

    // Reset mid-RUN with register 9 busy
    rs_i = {5'd20, 5'd9};
    #1;
    chk("pre_rst_busy", {62'd0, busy_o}, 64'd1);
    rst_i = 1'b0;
    #1;
    chk("mid_rst_busy", {62'd0, busy_o}, 64'd0);
    chk("mid_rst_done", {63'd0, init_done_o}, 64'd0);
    step();
    rst_i = 1'b1;
    wait_init(ncyc, sbad);
    chk("reinit_cycles", 64'(ncyc), 64'd32);
    rs_i = {5'd3, 5'd9};
    #1;
    chk("reinit_r9", src_o[63:0], 64'd0);
    chk("reinit_r3", src_o[127:64], 64'd0);
    chk("reinit_busy", {62'd0, busy_o}, 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
